// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the serial slice adder sequencer.
package serial_add_pkg;

    localparam int SLICE_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int slice_count(input int width);
        return width / SLICE_W;
    endfunction

endpackage

// File: rtl/add3_slice.sv
// Purely combinational 3-bit ripple-carry slice adder.
module add3_slice
    import serial_add_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, cin};

endmodule

// File: rtl/serial_add_sequencer.sv
// Wide adder built from one 3-bit slice, one slice per clock, LSB first.
// Optional saturation on carry-out is enabled by defining SERIAL_ADD_SAT_EN.
module serial_add_sequencer
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
`ifdef SERIAL_ADD_SAT_EN
    output logic             ovf,
`endif
    output logic             busy
);

    localparam int SLICES = slice_count(WIDTH);
    localparam int IDX_W  = (SLICES > 1) ? $clog2(SLICES) : 1;

    if ((WIDTH <= 0) || ((WIDTH % SLICE_W) != 0)) begin : g_bad_width
        $error("serial_add_sequencer: WIDTH must be a positive multiple of 3");
    end

    state_t             state_q, state_d;
    logic               in_ready_q, out_valid_q;
    logic [WIDTH-1:0]   a_q, b_q, sum_q;
    logic               carry_q;
    logic [IDX_W-1:0]   idx_q;
    logic               accept, last;
    logic [SLICE_W-1:0] slice_sum;
    logic               slice_cout;

    add3_slice u_slice (
        .a    (a_q[idx_q*SLICE_W +: SLICE_W]),
        .b    (b_q[idx_q*SLICE_W +: SLICE_W]),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        last    = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                last = (idx_q == IDX_W'(SLICES - 1));
                if (last) state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake flags are registered from the next state so neither depends
    // combinationally on in_valid/out_ready, and in_ready stays low in reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            a_q <= a;
            b_q <= b;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
        end else if (accept) begin
            sum_q   <= '0;
            carry_q <= cin;
            idx_q   <= '0;
        end else if (state_q == RUN) begin
            sum_q[idx_q*SLICE_W +: SLICE_W] <= slice_sum;
            carry_q <= slice_cout;
            idx_q   <= last ? '0 : idx_q + IDX_W'(1);
`ifdef SERIAL_ADD_SAT_EN
            if (last && slice_cout) sum_q <= '1;
`endif
        end
    end

`ifdef SERIAL_ADD_SAT_EN
    logic ovf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (accept || (state_d == IDLE)) begin
            ovf_q <= 1'b0;
        end else if ((state_q == RUN) && last && slice_cout) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf = ovf_q;
`endif

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = carry_q;
    assign busy      = (state_q == RUN);

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Directed bench for serial_add_sequencer (WIDTH=12 and WIDTH=3 instances).
module tb_serial_add_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
    logic [11:0] a, b, sum;
    logic        s3_in_valid, s3_in_ready, s3_cin, s3_out_valid, s3_out_ready;
    logic        s3_cout, s3_busy;
    logic [2:0]  s3_a, s3_b, s3_sum;
`ifdef SERIAL_ADD_SAT_EN
    logic        ovf, s3_ovf;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_add_sequencer #(.WIDTH(12)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout),
`ifdef SERIAL_ADD_SAT_EN
        .ovf(ovf),
`endif
        .busy(busy)
    );

    serial_add_sequencer #(.WIDTH(3)) dut3 (
        .clk(clk), .rst(rst), .in_valid(s3_in_valid), .in_ready(s3_in_ready),
        .a(s3_a), .b(s3_b), .cin(s3_cin), .out_valid(s3_out_valid),
        .out_ready(s3_out_ready), .sum(s3_sum), .cout(s3_cout),
`ifdef SERIAL_ADD_SAT_EN
        .ovf(s3_ovf),
`endif
        .busy(s3_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // Returns at the negedge right after the accept edge, operands scrambled.
    task automatic start_op(input logic [11:0] av, input logic [11:0] bv, input logic cv);
        int n = 0;
        while (!in_ready && n < 20) begin
            tick(1);
            n++;
        end
        check("in_ready_wait", in_ready, 1);
        a = av; b = bv; cin = cv; in_valid = 1'b1;
        tick(1);
        in_valid = 1'b0;
        a = ~av; b = ~bv; cin = ~cv;
    endtask

    initial begin
        logic stable;
        rst = 1'b1; in_valid = 0; a = 0; b = 0; cin = 0; out_ready = 1;
        s3_in_valid = 0; s3_a = 0; s3_b = 0; s3_cin = 0; s3_out_ready = 1;
        tick(2);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        tick(1);
        check("post_rst_in_ready", in_ready, 1);

        // 0xFFF + 0x001: carry through every slice
        start_op(12'hFFF, 12'h001, 1'b0);
        check("t1_busy", busy, 1);
        check("t1_in_ready", in_ready, 0);
        tick(3);
        check("t1_early_valid", out_valid, 0);
        tick(1);
        check("t1_out_valid", out_valid, 1);
`ifdef SERIAL_ADD_SAT_EN
        check("t1_sum", sum, 12'hFFF);
        check("t1_ovf", ovf, 1);
`else
        check("t1_sum", sum, 12'h000);
`endif
        check("t1_cout", cout, 1);
        tick(1);
        check("t1_valid_drop", out_valid, 0);
        check("t1_in_ready_back", in_ready, 1);

        // 0x123 + 0x456 + 1, in_ready low for 5 cycles
        start_op(12'h123, 12'h456, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("t2_in_ready_low", in_ready, 0);
            if (i == 4) begin
                check("t2_out_valid", out_valid, 1);
                check("t2_sum", sum, 12'h57A);
                check("t2_cout", cout, 0);
            end else begin
                tick(1);
            end
        end
        tick(1);
        check("t2_in_ready_back", in_ready, 1);

        // 0x5A5 + 0x0F0 held in DONE while in_valid pulses
        out_ready = 0;
        start_op(12'h5A5, 12'h0F0, 1'b0);
        tick(4);
        check("t3_out_valid", out_valid, 1);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = (i % 2 == 0);
            a = 12'($urandom); b = 12'($urandom);
            tick(1);
            if (!out_valid || sum !== 12'h695 || cout !== 1'b0 || in_ready || busy) stable = 1'b0;
        end
        in_valid = 0;
        check("t3_hold_stable", stable, 1);
        check("t3_sum", sum, 12'h695);
        out_ready = 1;
        tick(1);
        check("t3_valid_drop", out_valid, 0);
        check("t3_busy", busy, 0);
        check("t3_in_ready", in_ready, 1);

        // reset while slice 2 is pending
        start_op(12'hFFF, 12'hFFF, 1'b0);
        tick(2);
        rst = 1'b1;
        #1;
        check("t4_rst_out_valid", out_valid, 0);
        check("t4_rst_sum", sum, 0);
        check("t4_rst_busy", busy, 0);
        tick(1);
        rst = 1'b0;
        tick(1);
        start_op(12'h001, 12'h002, 1'b0);
        tick(4);
        check("t4_out_valid", out_valid, 1);
        check("t4_sum", sum, 12'h003);
        check("t4_cout", cout, 0);
        tick(1);

        // back-to-back with in_valid held high
        check("t5_in_ready", in_ready, 1);
        a = 12'h007; b = 12'h001; cin = 0; in_valid = 1;
        tick(1);
        a = 12'h800; b = 12'h800;
        tick(4);
        check("t5a_out_valid", out_valid, 1);
        check("t5a_sum", sum, 12'h008);
        check("t5a_cout", cout, 0);
        tick(5);
        check("t5b_early_valid", out_valid, 0);
        check("t5b_busy", busy, 1);
        tick(1);
        in_valid = 0;
        check("t5b_out_valid", out_valid, 1);
`ifdef SERIAL_ADD_SAT_EN
        check("t5b_sum", sum, 12'hFFF);
`else
        check("t5b_sum", sum, 12'h000);
`endif
        check("t5b_cout", cout, 1);
        tick(1);

        // WIDTH=3: single-slice RUN
        check("t6_in_ready", s3_in_ready, 1);
        s3_a = 3'd7; s3_b = 3'd7; s3_cin = 1; s3_in_valid = 1;
        tick(1);
        s3_in_valid = 0;
        check("t6_busy", s3_busy, 1);
        check("t6_early_valid", s3_out_valid, 0);
        tick(1);
        check("t6_out_valid", s3_out_valid, 1);
        check("t6_sum", s3_sum, 3'd7);
        check("t6_cout", s3_cout, 1);
        tick(1);
        check("t6_valid_drop", s3_out_valid, 0);
        s3_a = 3'd3; s3_b = 3'd2; s3_cin = 0; s3_in_valid = 1;
        tick(1);
        s3_in_valid = 0;
        tick(1);
        check("t6b_sum", s3_sum, 3'd5);
        check("t6b_cout", s3_cout, 0);
`ifdef SERIAL_ADD_SAT_EN
        check("t6b_ovf", s3_ovf, 0);
`endif
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
